// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: FSM encodings, JAL opcode, PC step
// and the J-type immediate decoder.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1
  } fetch_state_e;

  localparam logic [6:0] OPCODE_JAL = 7'b1101111;
  localparam int unsigned PC_STEP   = 4;

  // J-type immediate, sign-extended to 32 bits.
  function automatic logic signed [31:0] jal_imm(input logic [31:0] ins);
    return {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {pred, instr, pc} entries; head reads as zero when empty.
module fetch_queue #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok_s, pop_ok_s;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == {CW{1'b0}});
  assign push_ok_s = push_i && !full_o && !flush_i;
  assign pop_ok_s  = pop_i && !empty_o && !flush_i;
  assign count_o   = count_q;
  assign head_o    = empty_o ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else if (flush_i) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage is data only; validity is tracked by the count, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (push_ok_s) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, BOOT/RUN FSM, single-outstanding memory
// handshake and a fetch queue toward decode. Optional JAL predecode: FETCH_PREDECODE_EN.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     fetch_clock_in,
  input  logic                     fetch_reset_in,
  input  logic                     fetch_redirect_en_in,
  input  logic [XLEN-1:0]          fetch_redirect_addr_in,
  output logic                     fetch_ins_mem_valid_out,
  output logic [XLEN-1:0]          fetch_ins_mem_addr_out,
  input  logic                     fetch_ins_mem_ready_in,
  input  logic [31:0]              fetch_ins_mem_data_in,
  output logic                     fetch_dec_valid_out,
  input  logic                     fetch_dec_ready_in,
  output logic [XLEN-1:0]          fetch_dec_pc_out,
  output logic [31:0]              fetch_dec_ins_out,
  output logic                     fetch_dec_pred_out,
  output logic [$clog2(DEPTH):0]   fetch_count_out
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int W  = XLEN + 33;

  fetch_state_e     state_q;
  logic [XLEN-1:0]  pc_q, pc_d, next_pc_s;
  logic             pred_s, xfer_s, push_s, pop_s;
  logic             full_s, empty_s;
  logic [W-1:0]     head_s;
  logic [CW-1:0]    count_s;

  assign fetch_ins_mem_valid_out = (state_q == ST_RUN) && !full_s && !fetch_redirect_en_in;
  assign fetch_ins_mem_addr_out  = pc_q;
  assign xfer_s = fetch_ins_mem_valid_out && fetch_ins_mem_ready_in;
  assign push_s = xfer_s && !fetch_redirect_en_in;
  assign pop_s  = !empty_s && fetch_dec_ready_in && !fetch_redirect_en_in;

`ifdef FETCH_PREDECODE_EN
  always_comb begin
    pred_s = (fetch_ins_mem_data_in[6:0] == OPCODE_JAL);
    if (pred_s) begin
      next_pc_s = pc_q + XLEN'(jal_imm(fetch_ins_mem_data_in));
    end else begin
      next_pc_s = pc_q + XLEN'(PC_STEP);
    end
  end
  assign fetch_dec_pred_out = head_s[W-1];
`else
  assign pred_s             = 1'b0;
  assign next_pc_s          = pc_q + XLEN'(PC_STEP);
  assign fetch_dec_pred_out = 1'b0;
`endif

  // Redirect outranks any fetch progress in the same cycle.
  always_comb begin
    pc_d = pc_q;
    if (fetch_redirect_en_in) begin
      pc_d = {fetch_redirect_addr_in[XLEN-1:2], 2'b00};
    end else if (push_s) begin
      pc_d = next_pc_s;
    end else begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge fetch_clock_in or posedge fetch_reset_in) begin
    if (fetch_reset_in) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
    end else begin
      case (state_q)
        ST_BOOT: state_q <= ST_RUN;
        ST_RUN:  state_q <= ST_RUN;
        default: state_q <= ST_BOOT;
      endcase
      pc_q <= pc_d;
    end
  end

  fetch_queue #(
    .WIDTH (W),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_queue (
    .clk_i   (fetch_clock_in),
    .rst_i   (fetch_reset_in),
    .push_i  (push_s),
    .data_i  ({pred_s, fetch_ins_mem_data_in, pc_q}),
    .pop_i   (pop_s),
    .flush_i (fetch_redirect_en_in),
    .head_o  (head_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .count_o (count_s)
  );

  assign fetch_dec_valid_out = !empty_s;
  assign fetch_dec_pc_out    = head_s[XLEN-1:0];
  assign fetch_dec_ins_out   = head_s[XLEN+31:XLEN];
  assign fetch_count_out     = count_s;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed + pseudo-random bench for fetch_stage with a queue-based reference model.
module tb_fetch_stage;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            redir;
  logic [31:0]     redir_addr;
  logic            mem_valid;
  logic [31:0]     mem_addr;
  logic            mem_ready;
  logic [31:0]     mem_data;
  logic            dec_valid;
  logic            dec_ready;
  logic [31:0]     dec_pc;
  logic [31:0]     dec_ins;
  logic            dec_pred;
  logic [CW-1:0]   count;

  fetch_stage #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .fetch_clock_in          (clk),
    .fetch_reset_in          (rst),
    .fetch_redirect_en_in    (redir),
    .fetch_redirect_addr_in  (redir_addr),
    .fetch_ins_mem_valid_out (mem_valid),
    .fetch_ins_mem_addr_out  (mem_addr),
    .fetch_ins_mem_ready_in  (mem_ready),
    .fetch_ins_mem_data_in   (mem_data),
    .fetch_dec_valid_out     (dec_valid),
    .fetch_dec_ready_in      (dec_ready),
    .fetch_dec_pc_out        (dec_pc),
    .fetch_dec_ins_out       (dec_ins),
    .fetch_dec_pred_out      (dec_pred),
    .fetch_count_out         (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        pred;
  } ent_t;

  int          n_chk = 0;
  int          n_fail = 0;
  ent_t        mq[$];
  logic [31:0] mpc;
  bit          booted;
  bit          ovr_en = 1'b0;
  logic [31:0] ovr_addr, ovr_data;

  logic        o_valid, o_dvalid, o_pred;
  logic [31:0] o_addr, o_dpc, o_dins, o_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (ovr_en && a == ovr_addr) return ovr_data;
    else return 32'hA500_0000 ^ a;
  endfunction

  function automatic bit is_jal(input logic [31:0] ins);
`ifdef FETCH_PREDECODE_EN
    return ins[6:0] == 7'h6F;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] ins);
    int off;
    if (is_jal(ins)) begin
      off = (int'(ins[30:21]) * 2) + (int'(ins[20]) * 2048) + (int'(ins[19:12]) * 4096);
      if (ins[31]) off = off - 1048576;
      return pc + 32'(off);
    end else begin
      return pc + 32'd4;
    end
  endfunction

  // One cycle: drive inputs, compare against the model, advance the model.
  task automatic step(input logic r, input logic [31:0] ra, input logic rdy, input logic drdy);
    logic ev, pop, x;
    ent_t e;
    redir = r; redir_addr = ra; mem_ready = rdy; dec_ready = drdy;
    mem_data = mem_word(mpc);
    #1;
    o_valid = mem_valid; o_addr = mem_addr; o_dvalid = dec_valid;
    o_dpc = dec_pc; o_dins = dec_ins; o_pred = dec_pred; o_cnt = 32'(count);
    ev = booted && (mq.size() < DEPTH) && !r;
    chk("mem_valid", 32'(o_valid), 32'(ev));
    chk("mem_addr", o_addr, mpc);
    chk("dec_valid", 32'(o_dvalid), 32'(mq.size() > 0));
    chk("dec_pc", o_dpc, mq.size() > 0 ? mq[0].pc : 32'h0);
    chk("dec_ins", o_dins, mq.size() > 0 ? mq[0].ins : 32'h0);
    chk("dec_pred", 32'(o_pred), mq.size() > 0 ? 32'(mq[0].pred) : 32'h0);
    chk("count", o_cnt, 32'(mq.size()));
    if (r) begin
      mq.delete();
      mpc = ra & 32'hFFFF_FFFC;
    end else begin
      pop = (mq.size() > 0) && drdy;
      x   = ev && rdy;
      if (pop) void'(mq.pop_front());
      if (x) begin
        e.pc = mpc; e.ins = mem_data; e.pred = is_jal(mem_data);
        mq.push_back(e);
        mpc = model_next(mpc, mem_data);
      end
    end
    booted = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; redir = 1'b0; redir_addr = 32'h0; mem_ready = 1'b0;
    mem_data = 32'h0; dec_ready = 1'b0;
    #1;
    chk("rst_valid", 32'(mem_valid), 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_dvalid", 32'(dec_valid), 32'h0);
    chk("rst_dpc", dec_pc, 32'h0);
    chk("rst_dins", dec_ins, 32'h0);
    chk("rst_pred", 32'(dec_pred), 32'h0);
    mq.delete(); mpc = 32'h0; booted = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    @(negedge clk);
    do_reset();

    // Boot then sequential fetch
    step(1'b0, 32'h0, 1'b1, 1'b1); chk("boot_valid", 32'(o_valid), 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b1); chk("seq_a0", o_addr, 32'h0); chk("seq_v0", 32'(o_valid), 32'h1);
    step(1'b0, 32'h0, 1'b1, 1'b1); chk("seq_a4", o_addr, 32'h4); chk("seq_dpc0", o_dpc, 32'h0);
    chk("seq_dv", 32'(o_dvalid), 32'h1);
    step(1'b0, 32'h0, 1'b1, 1'b1); chk("seq_a8", o_addr, 32'h8);

    // Fill to full, then one pop
    step(1'b1, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("full_cnt", o_cnt, 32'd4); chk("full_valid", 32'(o_valid), 32'h0); chk("full_addr", o_addr, 32'h10);
    step(1'b0, 32'h0, 1'b1, 1'b1); chk("full_pop_valid", 32'(o_valid), 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("resume_valid", 32'(o_valid), 32'h1); chk("resume_addr", o_addr, 32'h10); chk("resume_cnt", o_cnt, 32'd3);

    // Stall with ready low
    step(1'b1, 32'h8, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 1'b0, 1'b1);
      chk("stall_valid", 32'(o_valid), 32'h1); chk("stall_addr", o_addr, 32'h8);
    end
    step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("stall_dpc", o_dpc, 32'h8); chk("stall_next", o_addr, 32'hC);

    // Redirect with count 3 to unaligned target
    step(1'b1, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h103, 1'b0, 1'b0);
    chk("rd_cnt3", o_cnt, 32'd3); chk("rd_valid_low", 32'(o_valid), 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("rd_cnt0", o_cnt, 32'd0); chk("rd_dvalid", 32'(o_dvalid), 32'h0);
    chk("rd_addr", o_addr, 32'h100); chk("rd_valid", 32'(o_valid), 32'h1);

    // Redirect coincident with ready and pop at 0x8
    step(1'b1, 32'h0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'h40, 1'b1, 1'b1);
    chk("co_addr8", o_addr, 32'h8); chk("co_vlow", 32'(o_valid), 32'h0); chk("co_dv", 32'(o_dvalid), 32'h1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("co_cnt", o_cnt, 32'd0); chk("co_dv0", 32'(o_dvalid), 32'h0); chk("co_addr", o_addr, 32'h40);
    step(1'b0, 32'h0, 1'b1, 1'b1); chk("co_dpc", o_dpc, 32'h40);

    // JAL predecode
    ovr_en = 1'b1; ovr_addr = 32'h20; ovr_data = 32'h0100_006F;
    step(1'b1, 32'h20, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1); chk("jal_req", o_addr, 32'h20);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("jal_dins", o_dins, 32'h0100_006F);
`ifdef FETCH_PREDECODE_EN
    chk("jal_next", o_addr, 32'h30); chk("jal_pred", 32'(o_pred), 32'h1);
`else
    chk("jal_next", o_addr, 32'h24); chk("jal_pred", 32'(o_pred), 32'h0);
`endif
    ovr_en = 1'b0;

    // PC wrap
    step(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1); chk("wrap_hi", o_addr, 32'hFFFF_FFFC);
    step(1'b0, 32'h0, 1'b1, 1'b1); chk("wrap_lo", o_addr, 32'h0);

    // Pseudo-random traffic against the model
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0, $urandom_range(0, 1023),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a stalled request
    step(1'b1, 32'h200, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0); chk("mid_valid", 32'(o_valid), 32'h1);
    do_reset();
    step(1'b0, 32'h0, 1'b1, 1'b1); chk("post_rst_boot", 32'(o_valid), 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b1); chk("post_rst_addr", o_addr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

endmodule
